// File: rtl/walk_arbiter_pkg.sv
// rtl/walk_arbiter_pkg.sv - shared state enum, default timing constants and sizing helper for walk_arbiter
package walk_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_X = 2'd1,
        WALK_Y = 2'd2,
        CLEAR  = 2'd3
    } walk_state_t;

    localparam int WALK_CYCLES_DEF  = 8;
    localparam int CLEAR_CYCLES_DEF = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/walk_btn_sync.sv
// rtl/walk_btn_sync.sv - two-flop synchronizer for one pedestrian button
module walk_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/walk_arbiter.sv
// rtl/walk_arbiter.sv - two-crossing pedestrian walk arbiter with round-robin tie break
// Optional button synchronizers enabled by macro WALK_ARB_SYNC_EN.
module walk_arbiter
    import walk_arbiter_pkg::*;
#(
    parameter int WALK_CYCLES  = WALK_CYCLES_DEF,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_x,
    input  logic btn_y,
    output logic walk_x,
    output logic walk_y,
    output logic busy
);

    localparam int CW = $clog2(max2(WALK_CYCLES, CLEAR_CYCLES) + 1);
    localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

    logic btn_x_s;
    logic btn_y_s;

`ifdef WALK_ARB_SYNC_EN
    walk_btn_sync u_sync_x (
        .clk (clk),
        .rst (rst),
        .d   (btn_x),
        .q   (btn_x_s)
    );

    walk_btn_sync u_sync_y (
        .clk (clk),
        .rst (rst),
        .d   (btn_y),
        .q   (btn_y_s)
    );
`else
    assign btn_x_s = btn_x;
    assign btn_y_s = btn_y;
`endif

    walk_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pend_x, pend_x_n;
    logic          pend_y, pend_y_n;
    logic          last_y, last_y_n;
    logic          grant_x;

    // last_y set means Y was served most recently, so X wins the next tie
    assign grant_x = pend_x && (!pend_y || last_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pend_x <= 1'b0;
            pend_y <= 1'b0;
            last_y <= 1'b1;
            walk_x <= 1'b0;
            walk_y <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pend_x <= pend_x_n;
            pend_y <= pend_y_n;
            last_y <= last_y_n;
            walk_x <= (state_n == WALK_X);
            walk_y <= (state_n == WALK_Y);
            busy   <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_y_n = last_y;

        case (state)
            IDLE: begin
                if (pend_x || pend_y) begin
                    state_n  = grant_x ? WALK_X : WALK_Y;
                    cnt_n    = WALK_LOAD;
                    last_y_n = !grant_x;
                end
            end
            WALK_X, WALK_Y: begin
                if (cnt == '0) begin
                    state_n = CLEAR;
                    cnt_n   = CLEAR_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            CLEAR: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (pend_x || pend_y) begin
                    state_n  = grant_x ? WALK_X : WALK_Y;
                    cnt_n    = WALK_LOAD;
                    last_y_n = !grant_x;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Presses on the crossing already walking are dropped; the grant edge clears the bit it serves
    always_comb begin
        pend_x_n = pend_x | (btn_x_s && (state != WALK_X));
        pend_y_n = pend_y | (btn_y_s && (state != WALK_Y));
        if ((state_n == WALK_X) && (state != WALK_X)) begin
            pend_x_n = 1'b0;
        end
        if ((state_n == WALK_Y) && (state != WALK_Y)) begin
            pend_y_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_walk_arbiter.sv
// tb/tb_walk_arbiter.sv - directed self-checking bench for walk_arbiter (WALK_CYCLES=4, CLEAR_CYCLES=2)
module tb_walk_arbiter;

`ifdef WALK_ARB_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_x = 1'b0;
    logic btn_y = 1'b0;
    logic walk_x;
    logic walk_y;
    logic busy;

    int total = 0;
    int bad = 0;
    int e = 0;

    walk_arbiter #(
        .WALK_CYCLES  (4),
        .CLEAR_CYCLES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_x  (btn_x),
        .btn_y  (btn_y),
        .walk_x (walk_x),
        .walk_y (walk_y),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ((walk_x && walk_y) !== 1'b0) begin
                bad++;
                $display("FAIL overlap t=%0t walk_x=%b walk_y=%b required not both 1", $time, walk_x, walk_y);
            end
        end
    end

    task automatic tick(input logic bx, input logic by);
        btn_x = bx;
        btn_y = by;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic apply_reset();
        btn_x = 1'b0;
        btn_y = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({walk_x, walk_y, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_state got=%b required=000", {walk_x, walk_y, busy});
        end
    endtask

    task automatic test_single();
        logic ex, eb;
        apply_reset();
        tick(1'b1, 1'b0);
        for (int k = 2; k <= 12 + L; k++) begin
            tick(1'b0, 1'b0);
            ex = (e >= 2 + L) && (e <= 5 + L);
            eb = (e >= 2 + L) && (e <= 7 + L);
            total++;
            if ({walk_x, walk_y, busy} !== {ex, 1'b0, eb}) begin
                bad++;
                $display("FAIL single edge=%0d got=%b required=%b", e, {walk_x, walk_y, busy}, {ex, 1'b0, eb});
            end
        end
    endtask

    task automatic test_tie();
        logic ex, ey, eb;
        apply_reset();
        tick(1'b1, 1'b1);
        for (int k = 2; k <= 16 + L; k++) begin
            tick(1'b0, 1'b0);
            ex = (e >= 2 + L) && (e <= 5 + L);
            ey = (e >= 8 + L) && (e <= 11 + L);
            eb = (e >= 2 + L) && (e <= 13 + L);
            total++;
            if ({walk_x, walk_y, busy} !== {ex, ey, eb}) begin
                bad++;
                $display("FAIL tie edge=%0d got=%b required=%b", e, {walk_x, walk_y, busy}, {ex, ey, eb});
            end
        end
    endtask

    task automatic test_ignore_latch();
        logic ex, ey;
        apply_reset();
        for (int k = 1; k <= 18 + L; k++) begin
            tick(k <= 5, k == 3);
            ex = (e >= 2 + L) && (e <= 5 + L);
            ey = (e >= 8 + L) && (e <= 11 + L);
            if (k >= 2) begin
                total++;
                if ({walk_x, walk_y} !== {ex, ey}) begin
                    bad++;
                    $display("FAIL ignore_latch edge=%0d got=%b required=%b", e, {walk_x, walk_y}, {ex, ey});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        for (int k = 3; k <= 3 + L; k++) tick(1'b0, 1'b0);
        total++;
        if (walk_x !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre got walk_x=%b required=1", walk_x);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({walk_x, walk_y, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_async got=%b required=000", {walk_x, walk_y, busy});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b0);
            total++;
            if ({walk_x, walk_y, busy} !== 3'b000) begin
                bad++;
                $display("FAIL reset_mid_after edge=%0d got=%b required=000", e, {walk_x, walk_y, busy});
            end
        end
    endtask

    task automatic test_fairness();
        logic ex, ey, eb;
        int d;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1, 1'b1);
            d = e - 2 - L;
            eb = (d >= 0);
            ex = (d >= 0) && ((d % 6) < 4) && (((d / 6) % 2) == 0);
            ey = (d >= 0) && ((d % 6) < 4) && (((d / 6) % 2) == 1);
            total++;
            if ({walk_x, walk_y, busy} !== {ex, ey, eb}) begin
                bad++;
                $display("FAIL fairness edge=%0d got=%b required=%b", e, {walk_x, walk_y, busy}, {ex, ey, eb});
            end
        end
        btn_x = 1'b0;
        btn_y = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_ignore_latch();
        test_reset_mid();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
